// File: rtl/mdio_mgmt_if.sv
// Host command port and MDIO frame-engine port of mdio_mgmt_sequencer.
// Optional macro MDIO_HOST_PHYAD_EN adds host_phy_ad for per-command PHY addressing.
interface mdio_mgmt_if;
    logic        host_req;
    logic        host_rw;
    logic [4:0]  host_reg_ad;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
`ifdef MDIO_HOST_PHYAD_EN
    logic [4:0]  host_phy_ad;
`endif
    logic        eng_start;
    logic        eng_rw;
    logic [4:0]  eng_phy_ad;
    logic [4:0]  eng_reg_ad;
    logic [15:0] eng_wdata;
    logic        eng_done;
    logic [15:0] eng_rdata;

`ifdef MDIO_HOST_PHYAD_EN
    modport slave (
        input  host_req, host_rw, host_reg_ad, host_wdata, host_phy_ad, eng_done, eng_rdata,
        output host_ack, host_rdata, eng_start, eng_rw, eng_phy_ad, eng_reg_ad, eng_wdata
    );
    modport master (
        output host_req, host_rw, host_reg_ad, host_wdata, host_phy_ad, eng_done, eng_rdata,
        input  host_ack, host_rdata, eng_start, eng_rw, eng_phy_ad, eng_reg_ad, eng_wdata
    );
`else
    modport slave (
        input  host_req, host_rw, host_reg_ad, host_wdata, eng_done, eng_rdata,
        output host_ack, host_rdata, eng_start, eng_rw, eng_phy_ad, eng_reg_ad, eng_wdata
    );
    modport master (
        output host_req, host_rw, host_reg_ad, host_wdata, eng_done, eng_rdata,
        input  host_ack, host_rdata, eng_start, eng_rw, eng_phy_ad, eng_reg_ad, eng_wdata
    );
`endif
endinterface

// File: rtl/mdio_mgmt_sequencer.sv
// MDIO management sequencer: PHY init table, init link polling, then host/poller arbitration.
// Optional macro MDIO_HOST_PHYAD_EN: host commands take their PHY address from host_phy_ad.
module mdio_mgmt_sequencer #(
    parameter logic [4:0] PHY_ADDR = 5'b10000,
    parameter int         POLL_GAP = 1024,
    parameter int         POLL_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mdio_mgmt_if.slave bus,
    output logic       init_done,
    output logic       init_err,
    output logic       link_up
);
    localparam int         TW       = $clog2(POLL_GAP + 1);
    localparam int         CW       = $clog2(POLL_MAX + 1);
    localparam logic [4:0] REG_BMSR = 5'd1;

    typedef enum logic [3:0] {
        RST_WAIT, INIT_WR, WAIT_ENG, INIT_POLL, WAIT_POLL, INIT_GAP,
        READY, HOST_ISSUE, HOST_WAIT, RUN_POLL, RUN_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic          tbl_idx, tbl_idx_nxt;
    logic [TW-1:0] poll_tmr;
    logic [CW-1:0] poll_cnt;
    logic          tmr_expired, poll_fin, last_poll, host_go;
    logic          iss, iss_rw;
    logic [4:0]    iss_phy, iss_reg;
    logic [15:0]   iss_wdata;

    function automatic logic [4:0] tbl_reg(input logic idx);
        return idx ? 5'd4 : 5'd0;
    endfunction

    function automatic logic [15:0] tbl_data(input logic idx);
        return idx ? 16'h01E1 : 16'h1301;
    endfunction

    assign tmr_expired = (poll_tmr == '0);
    assign poll_fin    = bus.eng_done && (state == WAIT_POLL || state == RUN_WAIT);
    assign last_poll   = ((poll_cnt + 1'b1) == CW'(POLL_MAX));
    // A request still high in the ack cycle belongs to the command just completed.
    assign host_go     = bus.host_req && !bus.host_ack;

    always_comb begin
        state_nxt   = state;
        tbl_idx_nxt = tbl_idx;
        case (state)
            RST_WAIT:   state_nxt = INIT_WR;
            INIT_WR:    state_nxt = WAIT_ENG;
            WAIT_ENG: begin
                if (bus.eng_done) begin
                    if (tbl_idx) begin
                        state_nxt = INIT_POLL;
                    end else begin
                        tbl_idx_nxt = 1'b1;
                        state_nxt   = INIT_WR;
                    end
                end
            end
            INIT_POLL:  state_nxt = WAIT_POLL;
            WAIT_POLL: begin
                if (bus.eng_done)
                    state_nxt = (bus.eng_rdata[2] || last_poll) ? READY : INIT_GAP;
            end
            INIT_GAP:   if (tmr_expired) state_nxt = INIT_POLL;
            READY: begin
                if (host_go)          state_nxt = HOST_ISSUE;
                else if (tmr_expired) state_nxt = RUN_POLL;
            end
            HOST_ISSUE: state_nxt = HOST_WAIT;
            HOST_WAIT:  if (bus.eng_done) state_nxt = READY;
            RUN_POLL:   state_nxt = RUN_WAIT;
            RUN_WAIT:   if (bus.eng_done) state_nxt = READY;
            default:    state_nxt = RST_WAIT;
        endcase
    end

    // Frame fields are decoded from the state being entered so they register with eng_start.
    always_comb begin
        iss       = 1'b0;
        iss_rw    = 1'b0;
        iss_phy   = PHY_ADDR;
        iss_reg   = 5'd0;
        iss_wdata = 16'h0000;
        case (state_nxt)
            INIT_WR: begin
                iss       = 1'b1;
                iss_reg   = tbl_reg(tbl_idx_nxt);
                iss_wdata = tbl_data(tbl_idx_nxt);
            end
            INIT_POLL, RUN_POLL: begin
                iss     = 1'b1;
                iss_rw  = 1'b1;
                iss_reg = REG_BMSR;
            end
            HOST_ISSUE: begin
                iss       = 1'b1;
                iss_rw    = bus.host_rw;
                iss_reg   = bus.host_reg_ad;
                iss_wdata = bus.host_wdata;
`ifdef MDIO_HOST_PHYAD_EN
                iss_phy   = bus.host_phy_ad;
`else
                iss_phy   = PHY_ADDR;
`endif
            end
            default: iss = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RST_WAIT;
            tbl_idx        <= 1'b0;
            poll_tmr       <= '0;
            poll_cnt       <= '0;
            init_done      <= 1'b0;
            init_err       <= 1'b0;
            link_up        <= 1'b0;
            bus.eng_start  <= 1'b0;
            bus.eng_rw     <= 1'b0;
            bus.eng_phy_ad <= 5'd0;
            bus.eng_reg_ad <= 5'd0;
            bus.eng_wdata  <= 16'h0000;
            bus.host_ack   <= 1'b0;
            bus.host_rdata <= 16'h0000;
        end else begin
            state         <= state_nxt;
            tbl_idx       <= tbl_idx_nxt;
            bus.eng_start <= iss;
            if (iss) begin
                bus.eng_rw     <= iss_rw;
                bus.eng_phy_ad <= iss_phy;
                bus.eng_reg_ad <= iss_reg;
                bus.eng_wdata  <= iss_wdata;
            end
            bus.host_ack <= (state == HOST_WAIT) && bus.eng_done;
            if ((state == HOST_WAIT) && bus.eng_done && bus.eng_rw)
                bus.host_rdata <= bus.eng_rdata;
            if (poll_fin) begin
                poll_tmr <= TW'(POLL_GAP);
                link_up  <= bus.eng_rdata[2];
            end else if (!tmr_expired) begin
                poll_tmr <= poll_tmr - 1'b1;
            end
            if ((state == WAIT_POLL) && bus.eng_done) begin
                poll_cnt <= poll_cnt + 1'b1;
                if (bus.eng_rdata[2] || last_poll)
                    init_done <= 1'b1;
                if (!bus.eng_rdata[2] && last_poll)
                    init_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mdio_mgmt_sequencer.sv
// Scoreboard bench for mdio_mgmt_sequencer: engine model plus monitor against queued expectations.
module tb_mdio_mgmt_sequencer;
    localparam int         POLL_GAP = 8;
    localparam int         POLL_MAX = 3;
    localparam int         LAT      = 4;
    localparam logic [4:0] PHY      = 5'b10000;

    typedef struct {
        logic        rw;
        logic [4:0]  ra;
        logic [15:0] wdata;
        logic [4:0]  phy;
    } cmd_t;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } ack_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done, init_err, link_up;

    mdio_mgmt_if bus ();

    mdio_mgmt_sequencer #(.PHY_ADDR(PHY), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .init_done(init_done), .init_err(init_err), .link_up(link_up)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    cmd_t host_q[$];
    cmd_t init_q[$];
    ack_t ack_q[$];

    // stimulus-side knobs, written only by the main process
    int          poll_mode = 1;     // 0: link down, 1: link up, 2: random
    logic        eng_hold = 1'b0;
    logic        force_en = 1'b0;
    logic [15:0] force_val = 16'h0000;
    logic        stray_tgl = 1'b0;

    // engine/monitor state, written only by the engine process
    int          cyc = 0;
    logic        busy = 1'b0;
    int          cnt = 0;
    cmd_t        cur;
    logic        cur_host = 1'b0;
    logic        cur_poll = 1'b0;
    logic [15:0] model_rdata = 16'h0000;
    int          poll_cnt_seen = 0;
    int          last_poll_done = -1;
    logic        link_chk = 1'b0;
    logic        link_exp = 1'b0;
    logic        stray_seen = 1'b0;

    function automatic logic [4:0] host_phy_exp(input cmd_t c);
`ifdef MDIO_HOST_PHYAD_EN
        return c.phy;
`else
        return PHY;
`endif
    endfunction

    function automatic void load_init();
        int n_polls;
        init_q.delete();
        init_q.push_back('{1'b0, 5'd0, 16'h1301, PHY});
        init_q.push_back('{1'b0, 5'd4, 16'h01E1, PHY});
        n_polls = (poll_mode == 0) ? POLL_MAX : 1;
        for (int i = 0; i < n_polls; i++) init_q.push_back('{1'b1, 5'd1, 16'h0000, PHY});
    endfunction

    initial begin
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 16'h0000;
    end

    always @(negedge clk) begin
        logic [15:0] rd;
        cmd_t e;
        ack_t a;
        cyc++;
        bus.eng_done = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
            load_init();
            ack_q.delete();
            poll_cnt_seen = 0;
            last_poll_done = -1;
            link_chk = 1'b0;
            model_rdata = 16'h0000;
        end else begin
            if (link_chk) begin
                chk("link_up_after_poll", link_up, link_exp);
                link_chk = 1'b0;
            end
            if (bus.host_ack) begin
                if (ack_q.size() == 0) begin
                    chk("host_ack_unexpected", bus.host_ack, 1'b0);
                end else begin
                    a = ack_q.pop_front();
                    chk("host_rdata", bus.host_rdata, a.rdata);
                    chk("host_ack_latency", cyc, a.cyc);
                    chk("host_ack_after_init", init_done, 1'b1);
                    chk("host_ack_no_start", bus.eng_start, 1'b0);
                end
            end
            if (busy && !(eng_hold && cur_host)) begin
                cnt--;
                if (cnt <= 0) begin
                    if (cur_poll) begin
                        case (poll_mode)
                            0:       rd = 16'h0000;
                            1:       rd = 16'h0004;
                            default: rd = 16'($urandom);
                        endcase
                    end else begin
                        rd = force_en ? force_val : 16'($urandom);
                    end
                    bus.eng_done  = 1'b1;
                    bus.eng_rdata = rd;
                    busy = 1'b0;
                    if (cur_poll) begin
                        poll_cnt_seen++;
                        last_poll_done = cyc;
                        link_chk = 1'b1;
                        link_exp = rd[2];
                    end
                    if (cur_host) begin
                        if (cur.rw) model_rdata = rd;
                        ack_q.push_back('{model_rdata, cyc + 1});
                    end
                end
            end
            if (stray_tgl != stray_seen) begin
                stray_seen = stray_tgl;
                bus.eng_done  = 1'b1;
                bus.eng_rdata = 16'hFFFF;
            end
            if (bus.eng_start) begin
                chk("one_outstanding", busy, 1'b0);
                cur = '{bus.eng_rw, bus.eng_reg_ad, bus.eng_wdata, bus.eng_phy_ad};
                busy = 1'b1;
                cnt = LAT;
                if (init_q.size() > 0) begin
                    e = init_q.pop_front();
                    chk("init_frame", {cur.rw, cur.ra, cur.phy, (cur.rw ? 16'h0000 : cur.wdata)},
                        {e.rw, e.ra, e.phy, e.wdata});
                    cur_poll = e.rw;
                    cur_host = 1'b0;
                end else if (cur.rw && cur.ra == 5'd1) begin
                    chk("poll_phy", cur.phy, PHY);
                    cur_poll = 1'b1;
                    cur_host = 1'b0;
                end else begin
                    cur_poll = 1'b0;
                    cur_host = 1'b1;
                    if (host_q.size() == 0) begin
                        chk("host_frame_unexpected", bus.eng_start, 1'b0);
                    end else begin
                        e = host_q.pop_front();
                        chk("host_frame", {cur.rw, cur.ra, cur.phy, (cur.rw ? 16'h0000 : cur.wdata)},
                            {e.rw, e.ra, host_phy_exp(e), (e.rw ? 16'h0000 : e.wdata)});
                    end
                end
                if (cur_poll && last_poll_done >= 0)
                    chk("poll_gap", 32'((cyc - last_poll_done) >= POLL_GAP), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_init_err", init_err, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_eng_start", bus.eng_start, 1'b0);
        chk("rst_host_ack", bus.host_ack, 1'b0);
        chk("rst_host_rdata", bus.host_rdata, 16'h0000);
        chk("rst_eng_fields", {bus.eng_rw, bus.eng_phy_ad, bus.eng_reg_ad, bus.eng_wdata}, 32'd0);
    endtask

    task automatic wait_init(input int limit);
        int n = 0;
        while (!init_done && n < limit) begin
            tick();
            n++;
        end
        chk("init_done_reached", init_done, 1'b1);
    endtask

    task automatic host_start(input cmd_t c);
        host_q.push_back(c);
        bus.host_rw     = c.rw;
        bus.host_reg_ad = c.ra;
        bus.host_wdata  = c.wdata;
`ifdef MDIO_HOST_PHYAD_EN
        bus.host_phy_ad = c.phy;
`endif
        bus.host_req    = 1'b1;
    endtask

    task automatic host_wait_ack(input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.host_ack && n < limit);
        chk("host_ack_seen", bus.host_ack, 1'b1);
        bus.host_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_t c;
        int   n;
        int   n0;
        bus.host_req    = 1'b0;
        bus.host_rw     = 1'b0;
        bus.host_reg_ad = 5'd0;
        bus.host_wdata  = 16'h0000;
`ifdef MDIO_HOST_PHYAD_EN
        bus.host_phy_ad = PHY;
`endif
        // init with link up: two table writes and one status read
        poll_mode = 1;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        wait_init(300);
        chk("p1_init_err", init_err, 1'b0);
        chk("p1_link_up", link_up, 1'b1);
        chk("p1_poll_count", poll_cnt_seen, 1);

        // init timeout with link down, host request held off during init
        poll_mode = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        host_start('{1'b1, 5'd3, 16'h0000, PHY});
        wait_init(500);
        chk("p2_init_err", init_err, 1'b1);
        chk("p2_link_up", link_up, 1'b0);
        chk("p2_poll_count", poll_cnt_seen, POLL_MAX);
        host_wait_ack(200);

        // host request on the cycle the poll timer expires
        poll_mode = 1;
        force_en  = 1'b1;
        force_val = 16'h0022;
        n0 = poll_cnt_seen;
        n = 0;
        while (poll_cnt_seen == n0 && n < 200) begin
            tick();
            n++;
        end
        chk("p3_poll_seen", 32'(poll_cnt_seen != n0), 32'd1);
        repeat (POLL_GAP) tick();
        host_start('{1'b1, 5'd2, 16'h0000, PHY});
        tick();
        chk("p3_start_latency", bus.eng_start, 1'b1);
        chk("p3_host_fields", {bus.eng_rw, bus.eng_phy_ad, bus.eng_reg_ad}, {1'b1, PHY, 5'd2});
        host_wait_ack(50);
        chk("p3_host_rdata", bus.host_rdata, 16'h0022);
        tick();
        chk("p3_poll_after_ack", {bus.eng_start, bus.eng_rw, bus.eng_reg_ad}, {1'b1, 1'b1, 5'd1});
        repeat (LAT + 3) tick();
        chk("p3_link_up", link_up, 1'b1);
        chk("p3_rdata_held", bus.host_rdata, 16'h0022);
        force_en = 1'b0;

        // randomized host traffic mixed with periodic polls
        poll_mode = 2;
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 12)) tick();
            c.rw    = 1'($urandom);
            c.ra    = 5'($urandom_range(0, 30));
            if (c.ra >= 5'd1) c.ra = c.ra + 5'd1;
            c.wdata = 16'($urandom);
            c.phy   = 5'($urandom);
            host_start(c);
            host_wait_ack(100);
        end

        // reset while a host frame is outstanding, then a stray completion
        poll_mode = 1;
        eng_hold  = 1'b1;
        host_start('{1'b0, 5'd5, 16'hBEEF, PHY});
        n = 0;
        while (!(bus.eng_start && bus.eng_reg_ad == 5'd5) && n < 100) begin
            tick();
            n++;
        end
        chk("p5_host_issued", bus.eng_start, 1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.host_req = 1'b0;
        stray_tgl = ~stray_tgl;
        check_reset_outputs();
        eng_hold = 1'b0;
        wait_init(300);
        chk("p5_init_err", init_err, 1'b0);
        chk("p5_link_up", link_up, 1'b1);
        chk("p5_no_ack", bus.host_ack, 1'b0);
        repeat (20) tick();
        chk("end_host_q_empty", host_q.size(), 0);
        chk("end_ack_q_empty", ack_q.size(), 0);
        chk("end_init_q_empty", init_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mdio_mgmt_sequencer.md
Name: mdio_mgmt_sequencer

Overview:
Controller in front of the MDIO frame engine, the block that serialises clause-22 frames on mdc/mdio.
- After reset it writes a fixed PHY init table, then polls the PHY status register until link is up or a timeout expires.
- Once init is done it shares the engine between a host requester and a periodic link poller.
- Only one engine command is ever outstanding.

Parameters:
PHY_ADDR, 5'b10000, PHY address used on every frame.
POLL_GAP, 1024, clk cycles from one poll completion to the next poll request (>=2).
POLL_MAX, 16, link polls during init before declaring timeout (>=1).

Ports:
clk  input  1  system clock; MDIO engine runs from this domain.
rst_n  input  1  synchronous active-low reset.
host_req  input  1  host command request; held high until host_ack.
host_rw  input  1  0=write, 1=read (engine sw encoding).
host_reg_ad  input  5  host register address.
host_wdata  input  16  host write data.
host_ack  output  1  one-cycle pulse when the host command completes.
host_rdata  output  16  read data; valid with host_ack and held until the next host_ack.
eng_start  output  1  one-cycle pulse launching a frame.
eng_rw  output  1  0=write, 1=read.
eng_phy_ad  output  5  frame PHY address.
eng_reg_ad  output  5  frame register address.
eng_wdata  output  16  frame write data.
eng_done  input  1  one-cycle pulse at end of frame.
eng_rdata  input  16  read data; valid with eng_done.
init_done  output  1  sticky until reset; init phase finished.
init_err  output  1  sticky until reset; init poll timed out.
link_up  output  1  status reg 1 bit 2 from the most recent poll.

Behaviour:
- Reset (rst_n=0 sampled at clk edge): state=RST_WAIT; all outputs 0; poll timer=0; poll count=0; table index=0.
- Init table, fixed, written in order:
  - entry 0: reg 5'd0, data 16'h1301.
  - entry 1: reg 5'd4, data 16'h01E1.
- States:
  - RST_WAIT: wait 1 cycle, then go to INIT_WR.
  - INIT_WR: pulse eng_start (rw=0, table entry), then go to WAIT_ENG.
  - WAIT_ENG: wait for eng_done. On eng_done go to the return state:
    - next table entry → INIT_WR;
    - table exhausted → INIT_POLL.
  - INIT_POLL: pulse eng_start (rw=1, reg 5'd1), then go to WAIT_POLL.
  - WAIT_POLL: on eng_done, link_up<=eng_rdata[2] and poll count +1.
    - If link_up: init_done<=1 → READY.
    - Else if count==POLL_MAX: init_done<=1, init_err<=1 → READY.
    - Else load the poll timer → INIT_GAP.
  - INIT_GAP: count POLL_GAP cycles → INIT_POLL.
  - READY: arbitrate.
    - host_req=1 → HOST_ISSUE.
    - Else if poll timer expired → RUN_POLL.
    - The poll timer runs in every state after init; it reloads on each poll completion.
  - HOST_ISSUE: pulse eng_start with host fields → HOST_WAIT.
  - HOST_WAIT: on eng_done:
    - host_ack=1 for one cycle;
    - host_rdata<=eng_rdata if rw=1, else unchanged;
    - → READY.
  - RUN_POLL / RUN_WAIT: same as INIT_POLL/WAIT_POLL but only update link_up → READY.
- Command fields:
  - eng_rw/eng_phy_ad/eng_reg_ad/eng_wdata are registered with eng_start.
  - They stay stable until eng_done.
- Arbitration:
  - Host has priority over a pending poll.
  - A deferred poll stays pending (not dropped) and is issued on the next READY with host_req=0.
- Host access before init:
  - host_req during init is held off; no host_ack until init_done=1.
  - host_req is sampled only in READY.
- Stray completions: eng_done outside the WAIT states is ignored.
- Engine hang: no eng_done timeout; the block waits indefinitely.
- Latency:
  - READY with host_req → eng_start on the next cycle.
  - eng_done → host_ack on the next cycle.
  - host_ack and a new eng_start are never in the same cycle.
- Reset mid-operation: immediately return to reset values and restart init. Aborting the engine frame is the engine's concern.

Optional Feature:
MDIO_HOST_PHYAD_EN.
- Defined: adds input host_phy_ad[4:0]; host commands use it for eng_phy_ad.
- Undefined: port absent; host commands use PHY_ADDR.
- Init and poll frames always use PHY_ADDR.

Test Plan:
- Release reset, engine model acks each frame 4 cycles after eng_start, rdata=16'h0004 → writes (reg0,16'h1301), (reg4,16'h01E1), one read of reg1; init_done=1, link_up=1, init_err=0.
- Engine read data always 16'h0000, POLL_MAX=3, POLL_GAP=8 → exactly 3 reg1 reads, ≥8 cycles between a poll's eng_done and the next eng_start; then init_done=1, init_err=1, link_up=0.
- After init, host read reg 5'd2, engine rdata=16'h0022 → eng_rw=1, eng_phy_ad=5'b10000, eng_reg_ad=5'd2; host_ack one cycle after eng_done; host_rdata=16'h0022 held.
- host_req asserted on the same cycle the poll timer expires → host frame first; poll issued right after host_ack with host_req low; link_up updated.
- host_req asserted during init → no eng_start with host fields and no host_ack before init_done=1; then serviced once.
- rst_n low for 1 cycle while in HOST_WAIT → all outputs 0 next cycle; a subsequent eng_done is ignored; init table restarts at entry 0.
